lbist_ora: RTL and testbench

//  MISR-based output response analyser (ORA) for the LBIST loop. It compacts CUT response

---
 rtl/lbist_ora.sv | 102 ++++++++++
 tb/tb_lbist_ora.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbist_ora.sv
// MISR-based output response analyser: compacts CUT responses into a signature,
// then compares signature and vector count against golden values when the TPG ends.
module lbist_ora #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] POLY       = 8'h1D,
    parameter logic [WIDTH-1:0] SEED       = '0,
    parameter logic [WIDTH-1:0] GOLDEN     = 8'h00,
    parameter int               N_PATTERNS = 255,
    parameter int               CW         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_en,
    input  logic [WIDTH-1:0] cut_out,
    input  logic             TPG_E,
    output logic             ORA_R,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    typedef enum logic [1:0] {
        IDLE,
        COMPACT,
        COMPARE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             fold;
    logic [WIDTH-1:0] sig;
    logic [WIDTH-1:0] sig_nxt;
    logic [WIDTH-1:0] feedback;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             match;

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        fold      = 1'b0;
        case (state)
            IDLE: begin
                fold = cap_en;
                if (TPG_E) begin
                    state_nxt = COMPARE;
                end else if (cap_en) begin
                    state_nxt = COMPACT;
                end
            end
            COMPACT: begin
                fold = cap_en;
                if (TPG_E) begin
                    state_nxt = COMPARE;
                end
            end
            COMPARE: state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // A vector arriving with TPG_E is still folded before the compare.
    always_comb begin
        feedback  = sig[WIDTH-1] ? POLY : '0;
        sig_nxt   = {sig[WIDTH-2:0], 1'b0} ^ feedback ^ cut_out;
        count_nxt = (count == '1) ? count : count + 1'b1;
        match     = (sig == GOLDEN) && (count == CW'(N_PATTERNS));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig   <= SEED;
            count <= '0;
            ORA_R <= 1'b0;
            pass  <= 1'b0;
        end else begin
            if (fold) begin
                sig   <= sig_nxt;
                count <= count_nxt;
            end
            if (state == COMPARE) begin
                ORA_R <= 1'b1;
                pass  <= match;
            end
        end
    end

    assign signature = sig;

endmodule

// File: tb/tb_lbist_ora.sv
// Scoreboard bench for lbist_ora: expected signatures are queued as vectors are
// driven and popped when the MISR updates; final verdicts come from a bench model.
module tb_lbist_ora;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, cap_en, tpg_e;
    logic [W-1:0] cut_out;
    logic         ora_r, pass;
    logic [W-1:0] signature;

    logic         rst_a, cap_en_a, tpg_e_a;
    logic [W-1:0] cut_out_a;
    logic         ora_r_a, pass_a;
    logic [W-1:0] signature_a;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_sig;
    int           model_cnt;

    always #5 clk = ~clk;

    lbist_ora #(
        .WIDTH(4), .POLY(4'b0011), .SEED(4'h0), .GOLDEN(4'h3), .N_PATTERNS(3), .CW(16)
    ) dut (
        .clk(clk), .rst(rst), .cap_en(cap_en), .cut_out(cut_out), .TPG_E(tpg_e),
        .ORA_R(ora_r), .pass(pass), .signature(signature)
    );

    // Non-zero seed exercises the feedback taps; golden = seed with zero patterns
    // makes an empty run pass.
    lbist_ora #(
        .WIDTH(4), .POLY(4'b0011), .SEED(4'b1000), .GOLDEN(4'b1000), .N_PATTERNS(0), .CW(16)
    ) dut_a (
        .clk(clk), .rst(rst_a), .cap_en(cap_en_a), .cut_out(cut_out_a), .TPG_E(tpg_e_a),
        .ORA_R(ora_r_a), .pass(pass_a), .signature(signature_a)
    );

    function automatic logic [W-1:0] misr_model(input logic [W-1:0] s, input logic [W-1:0] v);
        logic [W-1:0] shifted;
        shifted = {s[W-2:0], 1'b0};
        if (s[W-1]) shifted = shifted ^ 4'b0011;
        return shifted ^ v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_main();
        rst = 1'b1; cap_en = 1'b0; tpg_e = 1'b0; cut_out = '0;
        step();
        rst = 1'b0;
        model_sig = 4'h0;
        model_cnt = 0;
        exp_q.delete();
    endtask

    task automatic reset_aux();
        rst_a = 1'b1; cap_en_a = 1'b0; tpg_e_a = 1'b0; cut_out_a = '0;
        step();
        rst_a = 1'b0;
    endtask

    // Drive one response vector (optionally with TPG_E) and queue its expected signature.
    task automatic fold(input logic [W-1:0] v, input logic with_end);
        cut_out = v; cap_en = 1'b1; tpg_e = with_end;
        model_sig = misr_model(model_sig, v);
        model_cnt++;
        exp_q.push_back(model_sig);
        step();
        cap_en = 1'b0; tpg_e = 1'b0; cut_out = '0;
    endtask

    task automatic idle_cycles(input int n);
        cap_en = 1'b0; tpg_e = 1'b0; cut_out = 4'hF;
        for (int i = 0; i < n; i++) step();
        cut_out = '0;
    endtask

    task automatic test_reset();
        reset_main();
        checks++;
        if (signature !== 4'h0 || ora_r !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL reset: sig=%h ora_r=%b pass=%b, want sig=0 ora_r=0 pass=0", signature, ora_r, pass);
        end
    endtask

    task automatic test_golden();
        logic [W-1:0] vecs[3] = '{4'h1, 4'h2, 4'h3};
        logic [W-1:0] want;
        logic         exp_pass;
        reset_main();
        for (int i = 0; i < 3; i++) begin
            fold(vecs[i], 1'b0);
            want = exp_q.pop_front();
            checks++;
            if (signature !== want) begin
                errors++;
                $display("FAIL golden_sig%0d: got %h want %h", i, signature, want);
            end
        end
        checks++;
        if (signature !== 4'h3) begin
            errors++;
            $display("FAIL golden_final_sig: got %h want 3", signature);
        end
        tpg_e = 1'b1;
        step();
        tpg_e = 1'b0;
        checks++;
        if (ora_r !== 1'b0) begin
            errors++;
            $display("FAIL golden_latency: ora_r=%b one edge after TPG_E, want 0", ora_r);
        end
        step();
        exp_pass = (model_sig == 4'h3) && (model_cnt == 3);
        checks++;
        if (ora_r !== 1'b1 || pass !== exp_pass) begin
            errors++;
            $display("FAIL golden_result: ora_r=%b pass=%b, want ora_r=1 pass=%b", ora_r, pass, exp_pass);
        end
    endtask

    task automatic test_corrupt();
        logic [W-1:0] vecs[3] = '{4'h1, 4'h2, 4'h7};
        logic [W-1:0] want;
        reset_main();
        for (int i = 0; i < 3; i++) begin
            fold(vecs[i], 1'b0);
            want = exp_q.pop_front();
            checks++;
            if (signature !== want) begin
                errors++;
                $display("FAIL corrupt_sig%0d: got %h want %h", i, signature, want);
            end
        end
        tpg_e = 1'b1;
        step();
        tpg_e = 1'b0;
        step();
        checks++;
        if (signature !== 4'h7 || ora_r !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL corrupt_result: sig=%h ora_r=%b pass=%b, want sig=7 ora_r=1 pass=0", signature, ora_r, pass);
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] want;
        reset_main();
        fold(4'h1, 1'b0);
        idle_cycles(2);
        fold(4'h2, 1'b0);
        idle_cycles(3);
        checks++;
        if (signature !== model_sig) begin
            errors++;
            $display("FAIL gaps_hold: got %h want %h", signature, model_sig);
        end
        fold(4'h3, 1'b0);
        fold(4'h0, 1'b0);
        while (exp_q.size() > 1) void'(exp_q.pop_front());
        want = exp_q.pop_front();
        checks++;
        if (signature !== want || signature !== 4'h6) begin
            errors++;
            $display("FAIL gaps_final_sig: got %h want %h (6)", signature, want);
        end
        tpg_e = 1'b1;
        step();
        tpg_e = 1'b0;
        step();
        checks++;
        if (ora_r !== 1'b1 || pass !== 1'b0 || model_cnt != 4) begin
            errors++;
            $display("FAIL gaps_result: ora_r=%b pass=%b, want ora_r=1 pass=0 (count %0d)", ora_r, pass, model_cnt);
        end
    endtask

    task automatic test_same_cycle();
        logic [W-1:0] want;
        reset_main();
        fold(4'h1, 1'b0);
        fold(4'h2, 1'b0);
        fold(4'h3, 1'b1);
        while (exp_q.size() > 1) void'(exp_q.pop_front());
        want = exp_q.pop_front();
        checks++;
        if (signature !== want || ora_r !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_fold: sig=%h ora_r=%b, want sig=%h ora_r=0", signature, ora_r, want);
        end
        step();
        checks++;
        if (ora_r !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_result: ora_r=%b pass=%b, want 1 1", ora_r, pass);
        end
    endtask

    task automatic test_feedback();
        reset_aux();
        checks++;
        if (signature_a !== 4'b1000) begin
            errors++;
            $display("FAIL feedback_seed: got %b want 1000", signature_a);
        end
        cap_en_a = 1'b1; cut_out_a = 4'h0;
        step();
        cap_en_a = 1'b0;
        checks++;
        if (signature_a !== misr_model(4'b1000, 4'h0) || signature_a !== 4'b0011) begin
            errors++;
            $display("FAIL feedback_sig: got %b want 0011", signature_a);
        end
    endtask

    task automatic test_empty_run();
        reset_aux();
        tpg_e_a = 1'b1;
        step();
        tpg_e_a = 1'b0;
        step();
        checks++;
        if (ora_r_a !== 1'b1 || pass_a !== 1'b1 || signature_a !== 4'b1000) begin
            errors++;
            $display("FAIL empty_run: ora_r=%b pass=%b sig=%b, want 1 1 1000", ora_r_a, pass_a, signature_a);
        end
    endtask

    task automatic test_done_stimulus();
        logic [W-1:0] held;
        test_golden();
        held = signature;
        cap_en = 1'b1; tpg_e = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cut_out = 4'(i + 5);
            step();
            checks++;
            if (signature !== held || ora_r !== 1'b1 || pass !== 1'b1) begin
                errors++;
                $display("FAIL done_stable%0d: sig=%h ora_r=%b pass=%b, want sig=%h ora_r=1 pass=1",
                         i, signature, ora_r, pass, held);
            end
        end
        cap_en = 1'b0; tpg_e = 1'b0; cut_out = '0;
    endtask

    task automatic test_reset_midrun();
        reset_main();
        fold(4'h1, 1'b0);
        fold(4'h2, 1'b0);
        rst = 1'b1; cap_en = 1'b1; tpg_e = 1'b1; cut_out = 4'h5;
        step();
        rst = 1'b0; cap_en = 1'b0; tpg_e = 1'b0; cut_out = '0;
        checks++;
        if (signature !== 4'h0 || ora_r !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL reset_compact: sig=%h ora_r=%b pass=%b, want 0 0 0", signature, ora_r, pass);
        end
        step();
        checks++;
        if (ora_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_result: ora_r=%b after reset, want 0", ora_r);
        end
        test_done_stimulus();
        rst = 1'b1; cap_en = 1'b1; cut_out = 4'h9;
        step();
        rst = 1'b0; cap_en = 1'b0; cut_out = '0;
        checks++;
        if (signature !== 4'h0 || ora_r !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: sig=%h ora_r=%b pass=%b, want 0 0 0", signature, ora_r, pass);
        end
    endtask

    task automatic test_back_to_back();
        test_golden();
        test_corrupt();
        test_golden();
    endtask

    initial begin
        rst = 1'b1; cap_en = 1'b0; tpg_e = 1'b0; cut_out = '0;
        rst_a = 1'b1; cap_en_a = 1'b0; tpg_e_a = 1'b0; cut_out_a = '0;
        @(negedge clk);
        test_reset();
        test_golden();
        test_corrupt();
        test_gaps();
        test_same_cycle();
        test_feedback();
        test_empty_run();
        test_reset_midrun();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
